// File: rtl/hvsync_generator_pce_if.sv
// Video timing bundle between the sync generator (master) and a pixel consumer (slave).
// enable is the only input to the generator; every other signal is produced by it.
interface hvsync_generator_pce_if #(
    parameter int POS_W   = 9,
    parameter int FRAME_W = 8
);
    logic               enable;
    logic               hsync;
    logic               vsync;
    logic               display_on;
    logic [POS_W-1:0]   hpos;
    logic [POS_W-1:0]   vpos;
    logic               pix_ce;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_count;

    modport master (
        input  enable,
        output hsync, vsync, display_on, hpos, vpos,
        output pix_ce, line_start, frame_start, frame_count
    );

    modport slave (
        output enable,
        input  hsync, vsync, display_on, hpos, vpos,
        input  pix_ce, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/hvsync_generator_pce.sv
// Raster timing generator with a clock-enable pixel divider, programmable porches,
// sync polarities and a frame counter. Position-derived outputs are registered from next-state.
module hvsync_generator_pce #(
    parameter int H_DISPLAY = 256,
    parameter int H_BACK    = 60,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 25,
    parameter int V_DISPLAY = 240,
    parameter int V_TOP     = 18,
    parameter int V_BOTTOM  = 14,
    parameter int V_SYNC    = 4,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1,
    parameter int CLK_DIV   = 1,
    parameter int POS_W     = 9,
    parameter int FRAME_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    hvsync_generator_pce_if.master vid
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("hvsync_generator_pce: CLK_DIV must be at least 1");
    end
    if ((H_TOTAL - 1) > ((1 << POS_W) - 1)) begin : g_bad_h_width
        $error("hvsync_generator_pce: H_TOTAL-1 does not fit in POS_W bits");
    end
    if ((V_TOTAL - 1) > ((1 << POS_W) - 1)) begin : g_bad_v_width
        $error("hvsync_generator_pce: V_TOTAL-1 does not fit in POS_W bits");
    end

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] H_VIS    = POS_W'(H_DISPLAY);
    localparam logic [POS_W-1:0] V_VIS    = POS_W'(V_DISPLAY);
    localparam logic [POS_W-1:0] HS_FIRST = POS_W'(H_DISPLAY + H_FRONT);
    localparam logic [POS_W-1:0] HS_LAST  = POS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [POS_W-1:0] VS_FIRST = POS_W'(V_DISPLAY + V_BOTTOM);
    localparam logic [POS_W-1:0] VS_LAST  = POS_W'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    localparam logic HS_ON  = (HSYNC_POL != 0);
    localparam logic HS_OFF = (HSYNC_POL == 0);
    localparam logic VS_ON  = (VSYNC_POL != 0);
    localparam logic VS_OFF = (VSYNC_POL == 0);

    logic [DIV_W-1:0]   r_div;
    logic [POS_W-1:0]   r_hpos;
    logic [POS_W-1:0]   r_vpos;
    logic [FRAME_W-1:0] r_frame_count;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_display_on;
    logic               r_line_start;
    logic               r_frame_start;

    logic               w_pix_ce;
    logic               w_hwrap;
    logic               w_vwrap;
    logic [POS_W-1:0]   w_hpos_nxt;
    logic [POS_W-1:0]   w_vpos_nxt;

    // pix_ce is gated by reset so it reads 0 the instant reset asserts.
    assign w_pix_ce = vid.enable && reset && (r_div == DIV_LAST);
    assign w_hwrap  = (r_hpos == H_LAST);
    assign w_vwrap  = (r_vpos == V_LAST);

    always_comb begin
        w_hpos_nxt = r_hpos;
        w_vpos_nxt = r_vpos;
        if (w_pix_ce) begin
            w_hpos_nxt = w_hwrap ? '0 : r_hpos + 1'b1;
            if (w_hwrap) begin
                w_vpos_nxt = w_vwrap ? '0 : r_vpos + 1'b1;
            end
        end
    end

    // Decoded outputs are computed from the next position so they never lag hpos/vpos.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div         <= '0;
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_frame_count <= '0;
            r_hsync       <= HS_OFF;
            r_vsync       <= VS_OFF;
            r_display_on  <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (vid.enable) begin
            r_div         <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
            r_hpos        <= w_hpos_nxt;
            r_vpos        <= w_vpos_nxt;
            r_hsync       <= (w_hpos_nxt >= HS_FIRST && w_hpos_nxt <= HS_LAST) ? HS_ON : HS_OFF;
            r_vsync       <= (w_vpos_nxt >= VS_FIRST && w_vpos_nxt <= VS_LAST) ? VS_ON : VS_OFF;
            r_display_on  <= (w_hpos_nxt < H_VIS) && (w_vpos_nxt < V_VIS);
            r_line_start  <= w_pix_ce && w_hwrap;
            r_frame_start <= w_pix_ce && w_hwrap && w_vwrap;
            if (w_pix_ce && w_hwrap && w_vwrap) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign vid.hsync       = r_hsync;
    assign vid.vsync       = r_vsync;
    assign vid.display_on  = r_display_on;
    assign vid.hpos        = r_hpos;
    assign vid.vpos        = r_vpos;
    assign vid.pix_ce      = w_pix_ce;
    assign vid.line_start  = r_line_start && vid.enable;
    assign vid.frame_start = r_frame_start && vid.enable;
    assign vid.frame_count = r_frame_count;
endmodule

// File: tb/tb_hvsync_generator_pce.sv
// Bench for hvsync_generator_pce: two instances (CLK_DIV 1 / active-high syncs / FRAME_W 2 and
// CLK_DIV 3 / active-low syncs / FRAME_W 8) on a 14x7 raster, checked against an arithmetic model.
module tb_hvsync_generator_pce;
    localparam int HD = 8;
    localparam int HB = 2;
    localparam int HF = 2;
    localparam int HS = 2;
    localparam int VD = 4;
    localparam int VTP = 1;
    localparam int VB = 1;
    localparam int VS = 1;
    localparam int H_TOT = HD + HF + HS + HB;
    localparam int V_TOT = VD + VB + VS + VTP;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic en_a  = 1'b1;
    logic en_b  = 1'b1;
    always #5 clk = ~clk;

    hvsync_generator_pce_if #(.POS_W(9), .FRAME_W(2)) if_a ();
    hvsync_generator_pce_if #(.POS_W(9), .FRAME_W(8)) if_b ();
    assign if_a.enable = en_a;
    assign if_b.enable = en_b;

    hvsync_generator_pce #(
        .H_DISPLAY(HD), .H_BACK(HB), .H_FRONT(HF), .H_SYNC(HS),
        .V_DISPLAY(VD), .V_TOP(VTP), .V_BOTTOM(VB), .V_SYNC(VS),
        .HSYNC_POL(1), .VSYNC_POL(1), .CLK_DIV(1), .POS_W(9), .FRAME_W(2)
    ) u_a (.clk(clk), .reset(reset), .vid(if_a));

    hvsync_generator_pce #(
        .H_DISPLAY(HD), .H_BACK(HB), .H_FRONT(HF), .H_SYNC(HS),
        .V_DISPLAY(VD), .V_TOP(VTP), .V_BOTTOM(VB), .V_SYNC(VS),
        .HSYNC_POL(0), .VSYNC_POL(0), .CLK_DIV(3), .POS_W(9), .FRAME_W(8)
    ) u_b (.clk(clk), .reset(reset), .vid(if_b));

    logic [8:0] act_hp [2];
    logic [8:0] act_vp [2];
    logic [7:0] act_fc [2];
    logic       act_hs [2];
    logic       act_vs [2];
    logic       act_don[2];
    logic       act_pce[2];
    logic       act_ls [2];
    logic       act_fs [2];
    assign act_hp[0]  = if_a.hpos;        assign act_hp[1]  = if_b.hpos;
    assign act_vp[0]  = if_a.vpos;        assign act_vp[1]  = if_b.vpos;
    assign act_fc[0]  = {6'b0, if_a.frame_count};
    assign act_fc[1]  = if_b.frame_count;
    assign act_hs[0]  = if_a.hsync;       assign act_hs[1]  = if_b.hsync;
    assign act_vs[0]  = if_a.vsync;       assign act_vs[1]  = if_b.vsync;
    assign act_don[0] = if_a.display_on;  assign act_don[1] = if_b.display_on;
    assign act_pce[0] = if_a.pix_ce;      assign act_pce[1] = if_b.pix_ce;
    assign act_ls[0]  = if_a.line_start;  assign act_ls[1]  = if_b.line_start;
    assign act_fs[0]  = if_a.frame_start; assign act_fs[1]  = if_b.frame_start;

    // ---------------- scoreboard counters ----------------
    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b1;
    int n_edge  = 0;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[inst %0d] t=%0t got %0h expected %0h", name, inst, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The model only counts enabled clock edges since reset; everything else is arithmetic on that count.
    longint e_cnt[2]    = '{0, 0};
    bit     last_inc[2] = '{0, 0};

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_cnt[0]    <= 0;
            e_cnt[1]    <= 0;
            last_inc[0] <= 1'b0;
            last_inc[1] <= 1'b0;
        end else begin
            last_inc[0] <= en_a;
            last_inc[1] <= en_b;
            e_cnt[0]    <= e_cnt[0] + (en_a ? 1 : 0);
            e_cnt[1]    <= e_cnt[1] + (en_b ? 1 : 0);
        end
    end

    function automatic void model(input int i, input longint e, input bit en, input bit rst, input bit li,
                                  output logic [8:0] hp, output logic [8:0] vp, output logic [7:0] fc,
                                  output logic hs, output logic vs, output logic don,
                                  output logic pce, output logic ls, output logic fs);
        longint d;
        longint fw;
        logic   pol;
        longint p;
        d   = (i == 0) ? 1 : 3;
        fw  = (i == 0) ? 2 : 8;
        pol = (i == 0);
        p   = e / d;
        hp  = 9'(p % H_TOT);
        vp  = 9'((p / H_TOT) % V_TOT);
        fc  = 8'((p / (H_TOT * V_TOT)) % (longint'(1) << fw));
        hs  = (int'(hp) >= HD + HF && int'(hp) < HD + HF + HS) ? pol : !pol;
        vs  = (int'(vp) >= VD + VB && int'(vp) < VD + VB + VS) ? pol : !pol;
        don = (int'(hp) < HD) && (int'(vp) < VD);
        pce = rst && en && ((e % d) == d - 1);
        ls  = rst && en && li && (e > 0) && ((e % (d * H_TOT)) == 0);
        fs  = ls && ((e % (d * H_TOT * V_TOT)) == 0);
    endfunction

    logic [8:0] m_hp, m_vp;
    logic [7:0] m_fc;
    logic       m_hs, m_vs, m_don, m_pce, m_ls, m_fs;

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                model(i, e_cnt[i], (i == 0) ? en_a : en_b, reset, last_inc[i],
                      m_hp, m_vp, m_fc, m_hs, m_vs, m_don, m_pce, m_ls, m_fs);
                chk("hpos",        i, 32'(act_hp[i]),  32'(m_hp));
                chk("vpos",        i, 32'(act_vp[i]),  32'(m_vp));
                chk("frame_count", i, 32'(act_fc[i]),  32'(m_fc));
                chk("hsync",       i, 32'(act_hs[i]),  32'(m_hs));
                chk("vsync",       i, 32'(act_vs[i]),  32'(m_vs));
                chk("display_on",  i, 32'(act_don[i]), 32'(m_don));
                chk("pix_ce",      i, 32'(act_pce[i]), 32'(m_pce));
                chk("line_start",  i, 32'(act_ls[i]),  32'(m_ls));
                chk("frame_start", i, 32'(act_fs[i]),  32'(m_fs));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Returns 1 time unit after the requested posedge (counted since the last reset release).
    task automatic advance_to(input int target);
        while (n_edge < target) begin
            @(posedge clk);
            n_edge++;
        end
        #1;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        n_edge = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        #1 reset = 1'b0;
        #2;
        chk("lit_rst_hpos",    0, 32'(if_a.hpos), 32'd0);
        chk("lit_rst_hsync",   0, 32'(if_a.hsync), 32'd0);
        chk("lit_rst_hsync",   1, 32'(if_b.hsync), 32'd1);
        chk("lit_rst_vsync",   1, 32'(if_b.vsync), 32'd1);
        chk("lit_rst_display", 0, 32'(if_a.display_on), 32'd1);
        chk("lit_rst_pix_ce",  0, 32'(if_a.pix_ce), 32'd0);
        #9 reset = 1'b1;
        n_edge = 0;

        // Free-running raster with hand-computed checkpoints.
        advance_to(10);
        chk("lit_hpos10",  0, 32'(if_a.hpos), 32'd10);
        chk("lit_hsync10", 0, 32'(if_a.hsync), 32'd1);
        chk("lit_b_hpos",  1, 32'(if_b.hpos), 32'd3);
        advance_to(12);
        chk("lit_hsync12", 0, 32'(if_a.hsync), 32'd0);
        advance_to(14);
        chk("lit_wrap_hpos",  0, 32'(if_a.hpos), 32'd0);
        chk("lit_wrap_vpos",  0, 32'(if_a.vpos), 32'd1);
        chk("lit_line_start", 0, 32'(if_a.line_start), 32'd1);
        advance_to(42);
        chk("lit_b_line_start", 1, 32'(if_b.line_start), 32'd1);
        chk("lit_b_vpos",       1, 32'(if_b.vpos), 32'd1);
        chk("lit_a_vpos42",     0, 32'(if_a.vpos), 32'd3);
        advance_to(43);
        chk("lit_b_line_end", 1, 32'(if_b.line_start), 32'd0);
        chk("lit_b_hold",     1, 32'(if_b.hpos), 32'd0);
        advance_to(70);
        chk("lit_vsync_on", 0, 32'(if_a.vsync), 32'd1);
        chk("lit_vpos5",    0, 32'(if_a.vpos), 32'd5);
        advance_to(98);
        chk("lit_frame_start", 0, 32'(if_a.frame_start), 32'd1);
        chk("lit_frame_cnt1",  0, 32'(if_a.frame_count), 32'd1);
        advance_to(99);
        chk("lit_frame_end", 0, 32'(if_a.frame_start), 32'd0);
        advance_to(196);
        chk("lit_frame_cnt2", 0, 32'(if_a.frame_count), 32'd2);
        advance_to(210);
        chk("lit_b_vsync_low", 1, 32'(if_b.vsync), 32'd0);
        advance_to(294);
        chk("lit_b_frame_start", 1, 32'(if_b.frame_start), 32'd1);
        chk("lit_b_frame_cnt",   1, 32'(if_b.frame_count), 32'd1);
        advance_to(392);
        chk("lit_frame_wrap", 0, 32'(if_a.frame_count), 32'd0);

        // Freeze instance A at hpos 5 for 10 clocks.
        reset_pulse();
        advance_to(5);
        chk("lit_pre_freeze", 0, 32'(if_a.hpos), 32'd5);
        #1 en_a = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("lit_frozen_hpos",   0, 32'(if_a.hpos), 32'd5);
            chk("lit_frozen_pix_ce", 0, 32'(if_a.pix_ce), 32'd0);
        end
        #1 en_a = 1'b1;
        @(posedge clk);
        #1;
        chk("lit_resume_hpos", 0, 32'(if_a.hpos), 32'd6);

        // Asynchronous reset in the middle of a line.
        reset_pulse();
        advance_to(51);
        chk("lit_mid_hpos", 0, 32'(if_a.hpos), 32'd9);
        chk("lit_mid_vpos", 0, 32'(if_a.vpos), 32'd3);
        #2 reset = 1'b0;
        #1;
        chk("lit_async_hpos",    0, 32'(if_a.hpos), 32'd0);
        chk("lit_async_vpos",    0, 32'(if_a.vpos), 32'd0);
        chk("lit_async_display", 0, 32'(if_a.display_on), 32'd1);
        chk("lit_async_b_hsync", 1, 32'(if_b.hsync), 32'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        n_edge = 0;
        advance_to(1);
        chk("lit_post_hpos",   0, 32'(if_a.hpos), 32'd1);
        chk("lit_post_nofs",   0, 32'(if_a.frame_start), 32'd0);
        advance_to(98);
        chk("lit_post_fs",     0, 32'(if_a.frame_start), 32'd1);
        chk("lit_post_fcount", 0, 32'(if_a.frame_count), 32'd1);

        // Randomized enables with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            en_a = ($urandom_range(0, 9) < 8);
            en_b = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                #5 reset = 1'b1;
            end
        end

        @(posedge clk);
        #1 chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
